// File: rtl/clock_count_pkg.sv
// Shared constants, types and BCD helpers for the clock/time-keeping stage.
// Segment codes are active-low: bit0 = a ... bit6 = g, bit7 = DP.
package clock_count_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         DP_BIT    = 7;

    // Field limits kept in BCD so wrap detection is a plain compare.
    localparam logic [5:0] HOUR_MAX   = 6'h23;
    localparam logic [6:0] MINSEC_MAX = 7'h59;

    typedef struct packed {
        logic [5:0] hh;
        logic [6:0] mm;
        logic [6:0] ss;
    } bcd_time_t;

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        logic [7:0] code;
        case (d)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    function automatic logic [5:0] hour_inc(input logic [5:0] v);
        logic [5:0] r;
        if (v == HOUR_MAX)
            r = 6'h00;
        else if (v[3:0] == 4'd9)
            r = {v[5:4] + 2'd1, 4'd0};
        else
            r = {v[5:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [6:0] minsec_inc(input logic [6:0] v);
        logic [6:0] r;
        if (v == MINSEC_MAX)
            r = 7'h00;
        else if (v[3:0] == 4'd9)
            r = {v[6:4] + 3'd1, 4'd0};
        else
            r = {v[6:4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/clock_count_module_smg_encode.sv
// One BCD digit to an active-low 7-segment byte; blank overrides digit and DP.
module smg_encode_module
    import clock_count_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg = seg_digit(digit);
        if (dp)
            seg[DP_BIT] = 1'b0;
        if (blank)
            seg = SEG_BLANK;
    end

endmodule

// File: rtl/clock_count_module.sv
// HH:MM:SS BCD clock with a half-second prescaler, set-mode FSM and a
// registered six-digit segment output stage feeding the scan block.
module clock_count_module
    import clock_count_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Mode_Key,
    input  logic       Inc_Key,
    output logic [7:0] Ten_SMG_Data0,
    output logic [7:0] One_SMG_Data0,
    output logic [7:0] Ten_SMG_Data1,
    output logic [7:0] One_SMG_Data1,
    output logic [7:0] Ten_SMG_Data2,
    output logic [7:0] One_SMG_Data2,
    output logic [1:0] Mode_State
);

    localparam int             HALF_CNT = CLK_FREQ / 2;
    localparam int             PW       = (HALF_CNT > 1) ? $clog2(HALF_CNT) : 1;
    localparam logic [PW-1:0]  HALF_TC  = PW'(HALF_CNT - 1);

    mode_e          mode_q, mode_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic           phase_q, phase_d;
    bcd_time_t      time_q, time_d;
    logic           half_tick, sec_tick;

    logic [5:0][3:0] dig;
    logic [5:0]      blank;
    logic [5:0]      dp;
    logic [5:0][7:0] seg_d;
    logic [5:0][7:0] seg_q;

    assign half_tick = (presc_q == HALF_TC);
    // The second boundary is the half-tick that returns the phase to 0.
    assign sec_tick  = half_tick & phase_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q  <= MODE_RUN;
            presc_q <= '0;
            phase_q <= 1'b0;
            time_q  <= '0;
        end else begin
            mode_q  <= mode_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
            time_q  <= time_d;
        end
    end

    always_comb begin
        mode_d  = mode_q;
        presc_d = half_tick ? '0 : presc_q + PW'(1);
        phase_d = phase_q ^ half_tick;
        time_d  = time_q;
        case (mode_q)
            MODE_RUN: begin
                // A tick landing with Mode_Key is applied before the mode moves on.
                if (sec_tick) begin
                    time_d.ss = minsec_inc(time_q.ss);
                    if (time_q.ss == MINSEC_MAX) begin
                        time_d.mm = minsec_inc(time_q.mm);
                        if (time_q.mm == MINSEC_MAX)
                            time_d.hh = hour_inc(time_q.hh);
                    end
                end
                if (Mode_Key)
                    mode_d = MODE_SET_HOUR;
            end
            MODE_SET_HOUR: begin
                if (Mode_Key)
                    mode_d = MODE_SET_MIN;
                else if (Inc_Key)
                    time_d.hh = hour_inc(time_q.hh);
            end
            MODE_SET_MIN: begin
                if (Mode_Key) begin
                    // Leaving set mode restarts the second from a clean boundary.
                    mode_d    = MODE_RUN;
                    time_d.ss = 7'h00;
                    presc_d   = '0;
                    phase_d   = 1'b0;
                end else if (Inc_Key) begin
                    time_d.mm = minsec_inc(time_q.mm);
                end
            end
            default: mode_d = MODE_RUN;
        endcase
    end

    always_comb begin
        dig[0] = {2'b00, time_q.hh[5:4]};
        dig[1] = time_q.hh[3:0];
        dig[2] = {1'b0, time_q.mm[6:4]};
        dig[3] = time_q.mm[3:0];
        dig[4] = {1'b0, time_q.ss[6:4]};
        dig[5] = time_q.ss[3:0];

        blank    = '0;
        blank[0] = (mode_q == MODE_SET_HOUR) && phase_q;
        blank[1] = (mode_q == MODE_SET_HOUR) && phase_q;
        blank[2] = (mode_q == MODE_SET_MIN) && phase_q;
        blank[3] = (mode_q == MODE_SET_MIN) && phase_q;

        // Colon blink: DP after hours and minutes lit in the first half-second.
        dp    = '0;
        dp[1] = (mode_q == MODE_RUN) && !phase_q;
        dp[3] = (mode_q == MODE_RUN) && !phase_q;
    end

    for (genvar i = 0; i < 6; i++) begin : g_enc
        smg_encode_module u_enc (
            .digit (dig[i]),
            .blank (blank[i]),
            .dp    (dp[i]),
            .seg   (seg_d[i])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            seg_q <= {6{SEG_0}};
        else
            seg_q <= seg_d;
    end

    assign Ten_SMG_Data0 = seg_q[0];
    assign One_SMG_Data0 = seg_q[1];
    assign Ten_SMG_Data1 = seg_q[2];
    assign One_SMG_Data1 = seg_q[3];
    assign Ten_SMG_Data2 = seg_q[4];
    assign One_SMG_Data2 = seg_q[5];
    assign Mode_State    = mode_q;

endmodule

// File: tb/tb_clock_count_module.sv
// Bench for clock_count_module: directed steps plus random key traffic,
// checked every cycle against a wall-clock style reference model.
module tb_clock_count_module;

    localparam int CLK_FREQ = 8;
    localparam int HALF     = CLK_FREQ / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_key;
    logic       inc_key;
    logic [7:0] ten0, one0, ten1, one1, ten2, one2;
    logic [1:0] mode_state;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers for time, mode, and cycles since the
    // second boundary was last restarted.
    int m_h, m_m, m_s, m_mode, m_k;
    logic [7:0] seg_tab [10];
    logic [7:0] exp_seg [6];

    clock_count_module #(.CLK_FREQ(CLK_FREQ)) dut (
        .CLK           (clk),
        .RST           (rst),
        .Mode_Key      (mode_key),
        .Inc_Key       (inc_key),
        .Ten_SMG_Data0 (ten0),
        .One_SMG_Data0 (one0),
        .Ten_SMG_Data1 (ten1),
        .One_SMG_Data1 (one1),
        .Ten_SMG_Data2 (ten2),
        .One_SMG_Data2 (one2),
        .Mode_State    (mode_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] enc(input int d, input bit blank, input bit dp);
        logic [7:0] v;
        if (blank) return 8'hFF;
        v = seg_tab[d];
        if (dp) v[7] = 1'b0;
        return v;
    endfunction

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_k = 0;
    endtask

    task automatic model_expect();
        bit ph, bh, bm, dpl;
        ph  = ((m_k / HALF) % 2) == 1;
        bh  = (m_mode == 1) && ph;
        bm  = (m_mode == 2) && ph;
        dpl = (m_mode == 0) && !ph;
        exp_seg[0] = enc(m_h / 10, bh, 1'b0);
        exp_seg[1] = enc(m_h % 10, bh, dpl);
        exp_seg[2] = enc(m_m / 10, bm, 1'b0);
        exp_seg[3] = enc(m_m % 10, bm, dpl);
        exp_seg[4] = enc(m_s / 10, 1'b0, 1'b0);
        exp_seg[5] = enc(m_s % 10, 1'b0, 1'b0);
    endtask

    task automatic model_advance(input bit mk, input bit ik);
        bit tick, restart;
        int total;
        tick    = (m_k % CLK_FREQ) == (CLK_FREQ - 1);
        restart = 1'b0;
        case (m_mode)
            0: begin
                if (tick) begin
                    total = ((m_h * 60 + m_m) * 60 + m_s + 1) % 86400;
                    m_h = total / 3600;
                    m_m = (total / 60) % 60;
                    m_s = total % 60;
                end
                if (mk) m_mode = 1;
            end
            1: begin
                if (mk) m_mode = 2;
                else if (ik) m_h = (m_h + 1) % 24;
            end
            default: begin
                if (mk) begin
                    m_mode = 0; m_s = 0; restart = 1'b1;
                end else if (ik) begin
                    m_m = (m_m + 1) % 60;
                end
            end
        endcase
        m_k = restart ? 0 : m_k + 1;
    endtask

    task automatic check_outputs();
        chk("hour_tens", ten0, exp_seg[0]);
        chk("hour_ones", one0, exp_seg[1]);
        chk("min_tens",  ten1, exp_seg[2]);
        chk("min_ones",  one1, exp_seg[3]);
        chk("sec_tens",  ten2, exp_seg[4]);
        chk("sec_ones",  one2, exp_seg[5]);
        chk("mode", {6'b0, mode_state}, 8'(m_mode));
    endtask

    task automatic step(input bit mk, input bit ik);
        @(negedge clk);
        mode_key = mk;
        inc_key  = ik;
        model_expect();
        model_advance(mk, ik);
        @(posedge clk);
        #1;
        check_outputs();
        mode_key = 1'b0;
        inc_key  = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ten0"}, ten0, 8'hC0);
        chk({tag, "_one0"}, one0, 8'hC0);
        chk({tag, "_ten1"}, ten1, 8'hC0);
        chk({tag, "_one1"}, one1, 8'hC0);
        chk({tag, "_ten2"}, ten2, 8'hC0);
        chk({tag, "_one2"}, one2, 8'hC0);
        chk({tag, "_mode"}, {6'b0, mode_state}, 8'h00);
    endtask

    // Asserts reset between edges, checks it acts without a clock, then
    // releases it after a rising edge so the next step sees a full cycle.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("rst_async");
        @(posedge clk);
        #1;
        check_reset_values("rst_held");
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        seg_tab[0] = 8'hC0; seg_tab[1] = 8'hF9; seg_tab[2] = 8'hA4; seg_tab[3] = 8'hB0;
        seg_tab[4] = 8'h99; seg_tab[5] = 8'h92; seg_tab[6] = 8'h82; seg_tab[7] = 8'hF8;
        seg_tab[8] = 8'h80; seg_tab[9] = 8'h90;
        rst = 1'b1;
        mode_key = 1'b0;
        inc_key  = 1'b0;
        model_reset();
        #1;
        check_reset_values("por");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // First second arrives after CLK_FREQ edges, visible one edge later.
        run(9);
        chk("first_second", one2, 8'hF9);

        // Set 23:59, then run a full minute into the midnight rollover.
        step(1'b1, 1'b0);
        repeat (23) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        repeat (59) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        run(60 * CLK_FREQ + 1);
        chk("midnight_h10", ten0, 8'hC0);
        chk("midnight_m10", ten1, 8'hC0);
        chk("midnight_s10", ten2, 8'hC0);
        chk("midnight_s1",  one2, 8'hC0);

        // Hour wraps 23 -> 00 and minute wraps 59 -> 00 with no carry.
        step(1'b1, 1'b0);
        repeat (24) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        repeat (60) step(1'b0, 1'b1);
        run(2 * CLK_FREQ);
        step(1'b1, 1'b0);

        // Leave set mode with seconds at 37: seconds clear, prescaler restarts.
        run(37 * CLK_FREQ);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        run(2 * CLK_FREQ + 2);

        // Mode_Key wins over Inc_Key in SET_HOUR.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("mode_over_inc", {6'b0, mode_state}, 8'h02);
        run(CLK_FREQ);
        step(1'b1, 1'b0);
        run(3);

        // Random key traffic against the model.
        for (int i = 0; i < 700; i++)
            step($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);

        mid_reset();
        run(CLK_FREQ + 3);
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 10) == 0, $urandom_range(0, 1) == 0);
        mid_reset();
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
